activation_unit_pipe: RTL

- Multi-lane, mode-selectable activation stage placed between the MAC accumulator output and the writeback buffer.
- Processes LANES signed samples per beat and supports four activation modes: pass, ReLU, leaky ReLU and clamped ReLU.
- Two-stage pipeline with valid/ready handshake and full backpressure.
- Counts the lane-samples that clipped at the clamp ceiling.

---
 rtl/activation_unit_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/activation_unit_pipe.sv
// Two-stage, multi-lane activation (pass / ReLU / leaky / clamp) between the MAC
// accumulators and writeback, with valid/ready backpressure and a clamp-clip counter.

module activation_lane #(
  parameter int DATA_W     = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int CLAMP_MAX  = 6
) (
  input  logic signed [DATA_W-1:0] i_x,
  input  logic        [1:0]        i_mode,
  output logic        [DATA_W-1:0] o_y,
  output logic                     o_sat
);
  localparam logic signed [DATA_W-1:0] CMAX = DATA_W'(CLAMP_MAX);

  logic w_neg;
  assign w_neg = i_x[DATA_W-1];

  always_comb begin
    o_y   = i_x;
    o_sat = 1'b0;
    case (i_mode)
      2'd1: if (w_neg) o_y = '0;
      // arithmetic shift floors toward -inf; the most negative value cannot overflow
      2'd2: if (w_neg) o_y = i_x >>> LEAK_SHIFT;
      2'd3: begin
        if (w_neg) begin
          o_y = '0;
        end else if (i_x > CMAX) begin
          o_y   = CMAX;
          o_sat = 1'b1;
        end
      end
      default: o_y = i_x;
    endcase
  end
endmodule

module activation_unit_pipe #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CLAMP_MAX  = 6,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        sat_count,
  input  logic                    sat_clr
);
  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_LEAKY = 2'd2,
    MODE_CLAMP = 2'd3
  } act_mode_e;

  typedef struct packed {
    act_mode_e                     mode;
    logic [LANES-1:0][DATA_W-1:0] data;
  } s1_t;

  logic [2:1]                   r_vld_pipe;
  s1_t                          r_s1;
  logic [LANES-1:0][DATA_W-1:0] r_out;
  logic [CNT_W-1:0]             r_cnt;

  logic                         w_s1_load;
  logic                         w_s2_load;
  logic [LANES-1:0][DATA_W-1:0] w_y;
  logic [LANES-1:0]             w_sat;
  logic [CNT_W:0]               w_inc;
  logic [CNT_W:0]               w_sum;

  // ready depends only on register state and out_ready, never on in_valid
  assign w_s2_load = !r_vld_pipe[2] || out_ready;
  assign w_s1_load = !r_vld_pipe[1] || w_s2_load;
  assign in_ready  = w_s1_load;
  assign out_valid = r_vld_pipe[2];
  assign out_data  = r_out;
  assign sat_count = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe[1] <= 1'b0;
      r_s1          <= '0;
    end else if (w_s1_load) begin
      r_vld_pipe[1] <= in_valid;
      if (in_valid) begin
        r_s1.mode <= act_mode_e'(in_mode);
        r_s1.data <= in_data;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    activation_lane #(
      .DATA_W    (DATA_W),
      .LEAK_SHIFT(LEAK_SHIFT),
      .CLAMP_MAX (CLAMP_MAX)
    ) u_lane (
      .i_x   (r_s1.data[g]),
      .i_mode(r_s1.mode),
      .o_y   (w_y[g]),
      .o_sat (w_sat[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe[2] <= 1'b0;
      r_out         <= '0;
    end else if (w_s2_load) begin
      r_vld_pipe[2] <= r_vld_pipe[1];
      if (r_vld_pipe[1]) r_out <= w_y;
    end
  end

  // clipped lanes count only when a valid beat actually moves into stage 2
  always_comb begin
    w_inc = '0;
    if (w_s2_load && r_vld_pipe[1]) begin
      for (int i = 0; i < LANES; i++) w_inc = w_inc + (CNT_W+1)'(w_sat[i]);
    end
    w_sum = {1'b0, r_cnt} + w_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_cnt <= '0;
    else if (sat_clr)      r_cnt <= '0;
    else if (w_sum[CNT_W]) r_cnt <= '1;
    else                   r_cnt <= w_sum[CNT_W-1:0];
  end
endmodule
